// File: rtl/jk_counter_pkg.sv
// ---------------------------------------------------------------------------
// jk_counter_pkg
// Shared definitions for the JK-based modulo counter.
// Provides the JK command encodings as {j,k} pairs and the excitation helper
// that turns a present bit and a desired next bit into the JK command that
// moves a JK cell from one to the other.
// No ports (package).
// ---------------------------------------------------------------------------
package jk_counter_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // The toggle code is never produced here. A rising bit is driven with SET.
  // A falling bit is driven with RESET. Everything else holds.
  function automatic logic [1:0] jk_excite(input logic q, input logic n);
    jk_excite = {n & ~q, q & ~n};
  endfunction

endpackage

// File: rtl/jk_mod_counter_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// Single JK storage cell with synchronous active-low reset.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  synchronous reset, active-low, clears q
//   j     in  J command
//   k     in  K command
//   q     out stored bit
// ---------------------------------------------------------------------------
module jk_cell
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  // Full JK truth table: hold, reset, set, toggle. Reset is sampled on the
  // clock edge and wins over any J/K command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:  q_q <= q_q;
        JK_RESET: q_q <= 1'b0;
        JK_SET:   q_q <= 1'b1;
        default:  q_q <= ~q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// ---------------------------------------------------------------------------
// jk_mod_counter
// Modulo-MODULUS up/down counter built from WIDTH JK cells. The block first
// computes the target count from the present count and the controls. It then
// turns each bit into a J/K command and applies that command to the cells.
// Ports:
//   clk      in  rising-edge clock
//   rst_n    in  synchronous reset, active-low
//   en       in  count enable
//   up       in  1 = increment, 0 = decrement
//   load     in  parallel load, priority over en
//   load_val in  value to load, clamped to MODULUS-1
//   count    out present count (JK cell outputs)
//   tc       out terminal count, combinational
//   carry    out registered one-cycle pulse after a wrap
//   j_vec    out J command per bit, combinational
//   k_vec    out K command per bit, combinational
// ---------------------------------------------------------------------------
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
);

  // A modulus outside 2..2**WIDTH cannot be represented. Stop elaboration
  // instead of building a counter that cannot work.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "jk_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] target_d;
  logic             wrap_d;
  logic             carry_q;

  // Target selection. Priority is load, then count, then hold.
  // Any count at or above MAX_CNT counts as terminal when going up, so a
  // corrupted count returns to 0. Going down, a corrupted count returns to
  // MAX_CNT without flagging a wrap.
  always_comb begin
    target_d = count;
    wrap_d   = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        target_d = load_val;
      end else begin
        target_d = MAX_CNT;
      end
    end else if (en) begin
      if (up) begin
        if (count >= MAX_CNT) begin
          target_d = '0;
          wrap_d   = 1'b1;
        end else begin
          target_d = WIDTH'({1'b0, count} + (WIDTH + 1)'(1));
        end
      end else begin
        if (count == '0) begin
          target_d = MAX_CNT;
          wrap_d   = 1'b1;
        end else if (count > MAX_CNT) begin
          target_d = MAX_CNT;
        end else begin
          target_d = WIDTH'({1'b0, count} - (WIDTH + 1)'(1));
        end
      end
    end
  end

  // Per-bit excitation and the JK cell bank. The reset is applied inside
  // each cell, so the J/K outputs stay a pure function of count and the
  // controls.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign {j_vec[i], k_vec[i]} = jk_excite(count[i], target_d[i]);

    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (count[i])
    );
  end

  // Carry register. It follows the wrap decision of the edge that just
  // happened. Back-to-back wraps therefore keep it high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= wrap_d;
    end
  end

  assign carry = carry_q;
  assign tc    = up ? (count == MAX_CNT) : (count == '0);

endmodule

// File: tb/tb_jk_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_mod_counter
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10).
// A modulo-arithmetic reference model predicts each output. The bench also
// checks one standalone jk_cell, including the toggle code.
// ---------------------------------------------------------------------------
module tb_jk_mod_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             carry;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  logic cj;
  logic ck;
  logic cq;

  int vectors     = 0;
  int miscompares = 0;

  int   mCount = 0;
  logic mCarry = 1'b0;

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .carry    (carry),
    .j_vec    (j_vec),
    .k_vec    (k_vec)
  );

  jk_cell u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (cj),
    .k     (ck),
    .q     (cq)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One comparison. A mismatch is counted and reported with its tag.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controls at the falling edge and check the
  // combinational outputs against the model. After the rising edge, advance
  // the model and check the registered outputs.
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [WIDTH-1:0] lv);
    int         nxt;
    logic       wrap;
    logic [3:0] curB;
    logic [3:0] nxtB;
    @(negedge clk);
    rst_n    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    wrap     = 1'b0;
    if (l) begin
      nxt = (int'(lv) < MOD) ? int'(lv) : MOD - 1;
    end else if (e) begin
      if (u) begin
        nxt  = (mCount + 1) % MOD;
        wrap = (mCount == MOD - 1);
      end else begin
        nxt  = (mCount + MOD - 1) % MOD;
        wrap = (mCount == 0);
      end
    end else begin
      nxt = mCount;
    end
    curB = 4'(mCount);
    nxtB = 4'(nxt);
    #1;
    checkOutput("tc",    32'(tc),    32'(u ? (mCount == MOD - 1) : (mCount == 0)));
    checkOutput("j_vec", 32'(j_vec), 32'(nxtB & ~curB));
    checkOutput("k_vec", 32'(k_vec), 32'(curB & ~nxtB));
    @(posedge clk);
    #1;
    if (!r) begin
      mCount = 0;
      mCarry = 1'b0;
    end else begin
      mCount = nxt;
      mCarry = wrap;
    end
    checkOutput("count", 32'(count), 32'(mCount));
    checkOutput("carry", 32'(carry), 32'(mCarry));
  endtask

  initial begin
    logic [1:0] cellJk [4];
    logic       cellQ  [4];
    rst_n    = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b1;
    load_val = 4'd7;
    cj       = 1'b0;
    ck       = 1'b0;

    // Reset overrides load and enable for two cycles.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);

    // Standalone cell: hold, reset, set, then toggle, starting from 0.
    cellJk = '{2'b00, 2'b01, 2'b10, 2'b11};
    cellQ  = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b0;
      load  = 1'b0;
      cj    = cellJk[i][1];
      ck    = cellJk[i][0];
      @(posedge clk);
      #1;
      checkOutput("cell_q", 32'(cq), 32'(cellQ[i]));
    end

    // Up count through a wrap.
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

    // Down count through a wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // Load priority, clamp and hold.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd13);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

    // Reset in the middle of an up count, then resume.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) != 0),
                    ($urandom_range(0, 3) != 0),
                    1'($urandom),
                    ($urandom_range(0, 7) == 0),
                    4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
